// File: rtl/key_onehot_src.sv
// key_onehot_src: synchronizes and debounces four keys, presenting one press at a time as a one-hot word with VALID/ACK.
// Define KEY_PEND_EN to queue presses that arrive while a word is presented; otherwise such presses are dropped and flag OVF.
module key_onehot_src #(
    parameter int CNT_W = 2
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic [3:0] KEY,
    input  logic       ACK,
    output logic [3:0] D,
    output logic       VALID,
    output logic       OVF
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state_q, state_d;
    logic [3:0] s1_q, ks_q, kd_q, kd_d, kdp_q, d_q, d_d, ev, sel;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic ovf_q, ovf_d;
`ifdef KEY_PEND_EN
    logic [3:0] pend_q, pend_d, c, held;
`endif
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            kd_d[i] = kd_q[i];
            cnt_d[i] = '0;
            if (ks_q[i] != kd_q[i]) begin
                // the N-th consecutive mismatch flips the debounced level
                if (cnt_q[i] == {CNT_W{1'b1}}) kd_d[i] = ~kd_q[i];
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        d_d = d_q;
        ovf_d = ovf_q;
        ev = kd_q & ~kdp_q;
`ifdef KEY_PEND_EN
        pend_d = pend_q;
        c = pend_q | ev;
        sel = c & (~c + 4'd1);
        held = (state_q == PRESENT && !ACK) ? d_q : 4'b0000;
        ovf_d = ovf_q | (|(ev & (pend_q | held)));
        if (state_q == IDLE || ACK) begin
            state_d = (|c) ? PRESENT : IDLE;
            d_d = sel;
            pend_d = c & ~sel;
        end else begin
            pend_d = pend_q | (ev & ~d_q);
        end
`else
        sel = ev & (~ev + 4'd1);
        if (state_q == IDLE) begin
            state_d = (|ev) ? PRESENT : IDLE;
            d_d = sel;
            ovf_d = ovf_q | (|(ev & ~sel));
        end else begin
            ovf_d = ovf_q | (|ev);
            if (ACK) begin
                state_d = IDLE;
                d_d = 4'b0000;
            end
        end
`endif
    end
    always_ff @(posedge CLK) begin
        if (!_RST) begin
            s1_q <= '0;
            ks_q <= '0;
            kd_q <= '0;
            kdp_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            state_q <= IDLE;
            d_q <= '0;
            ovf_q <= 1'b0;
`ifdef KEY_PEND_EN
            pend_q <= '0;
`endif
        end else begin
            s1_q <= KEY;
            ks_q <= s1_q;
            kd_q <= kd_d;
            kdp_q <= kd_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            d_q <= d_d;
            ovf_q <= ovf_d;
`ifdef KEY_PEND_EN
            pend_q <= pend_d;
`endif
        end
    end
    assign D = d_q;
    assign VALID = (state_q == PRESENT);
    assign OVF = ovf_q;
endmodule

// File: tb/tb_key_onehot_src.sv
// tb_key_onehot_src: random and directed stimulus checked every cycle against a behavioural press/queue model.
module tb_key_onehot_src;
    localparam int N = 4;
    logic CLK = 0, rst_n = 0, ACK = 0;
    logic [3:0] KEY = 0;
    logic [3:0] D;
    logic VALID, OVF;
    int checks = 0, passed = 0;
    bit chk_en = 0;
    logic [3:0] m_s1, m_ks, m_kd, m_kdp, m_pend, m_d, ev, c, lost;
    logic m_v, m_ovf;
    int m_run [4];

    key_onehot_src #(.CNT_W(2)) dut (.CLK(CLK), ._RST(rst_n), .KEY(KEY), .ACK(ACK), .D(D), .VALID(VALID), .OVF(OVF));

    always #5 CLK = ~CLK;

    function automatic logic [3:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 4'b0001 << i;
        return 4'b0000;
    endfunction

    // reference: edge-by-edge behaviour built from run lengths and pending sets
    always @(posedge CLK) begin
        if (!rst_n) begin
            m_s1 = 0; m_ks = 0; m_kd = 0; m_kdp = 0; m_pend = 0; m_d = 0; m_v = 0; m_ovf = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            ev = m_kd & ~m_kdp;
            m_kdp = m_kd;
            for (int i = 0; i < 4; i++) begin
                if (m_ks[i] == m_kd[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == N) begin m_kd[i] = ~m_kd[i]; m_run[i] = 0; end
                end
            end
            m_ks = m_s1;
            m_s1 = KEY;
`ifdef KEY_PEND_EN
            lost = ev & (m_pend | ((m_v && !ACK) ? m_d : 4'b0000));
            c = m_pend | ev;
            if (!m_v || ACK) begin
                m_d = lowest(c);
                m_v = (c != 0);
                m_pend = c & ~m_d;
            end else m_pend = m_pend | (ev & ~m_d);
`else
            if (!m_v) begin
                m_d = lowest(ev);
                m_v = (ev != 0);
                lost = ev & ~m_d;
            end else begin
                lost = ev;
                if (ACK) begin m_d = 0; m_v = 0; end
            end
`endif
            if (lost != 0) m_ovf = 1;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) if (chk_en) begin
        chk("cyc_D", D, m_d);
        chk("cyc_VALID", {3'b0, VALID}, {3'b0, m_v});
        chk("cyc_OVF", {3'b0, OVF}, {3'b0, m_ovf});
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (VALID !== 1'b1 && n < lim) begin @(negedge CLK); n++; end
        chk("wait_valid", {3'b0, VALID}, 4'b0001);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(2);
        rst_n = 1;
    endtask

    initial begin
        step(2);
        chk_en = 1;
        chk("rst_D", D, 4'b0000);
        chk("rst_VALID", {3'b0, VALID}, 4'b0000);
        chk("rst_OVF", {3'b0, OVF}, 4'b0000);
        rst_n = 1;
        KEY = 4'b0100;
        step(6);
        chk("lat_not_yet", {3'b0, VALID}, 4'b0000);
        step(1);
        chk("lat_VALID", {3'b0, VALID}, 4'b0001);
        chk("lat_D", D, 4'b0100);
        chk("model_D", m_d, 4'b0100);
        ACK = 1;
        step(1);
        ACK = 0;
        chk("ack_D", D, 4'b0000);
        chk("ack_VALID", {3'b0, VALID}, 4'b0000);
        chk("ack_OVF", {3'b0, OVF}, 4'b0000);
        KEY = 4'b0110;
        step(3);
        KEY = 4'b0100;
        step(10);
        chk("glitch_VALID", {3'b0, VALID}, 4'b0000);
        chk("glitch_D", D, 4'b0000);
        KEY = 4'b0000;
        step(8);
        KEY = 4'b1010;
        ACK = 1;
        wait_valid(20);
        chk("multi_first", D, 4'b0010);
        step(1);
`ifdef KEY_PEND_EN
        chk("multi_second", D, 4'b1000);
        chk("multi_b2b_VALID", {3'b0, VALID}, 4'b0001);
        step(1);
        chk("multi_OVF", {3'b0, OVF}, 4'b0000);
`else
        chk("multi_OVF", {3'b0, OVF}, 4'b0001);
`endif
        chk("multi_end_VALID", {3'b0, VALID}, 4'b0000);
        chk("model_multi", {3'b0, m_v}, 4'b0000);
        ACK = 0;
        KEY = 4'b0000;
        step(8);
        do_reset();
        KEY = 4'b0001;
        wait_valid(20);
        chk("hold_D", D, 4'b0001);
        KEY = 4'b0101;
        step(8);
`ifdef KEY_PEND_EN
        chk("pend_OVF", {3'b0, OVF}, 4'b0000);
`else
        chk("pend_OVF", {3'b0, OVF}, 4'b0001);
`endif
        KEY = 4'b0001;
        step(8);
        KEY = 4'b0101;
        step(8);
        chk("second_OVF", {3'b0, OVF}, 4'b0001);
        ACK = 1;
        step(1);
        ACK = 0;
`ifdef KEY_PEND_EN
        chk("pend_pres_D", D, 4'b0100);
`else
        chk("nopend_VALID", {3'b0, VALID}, 4'b0000);
`endif
        chk("ovf_sticky", {3'b0, OVF}, 4'b0001);
        KEY = 4'b1101;
        step(8);
        KEY = 4'b1000;
        rst_n = 0;
        step(1);
        chk("midrst_D", D, 4'b0000);
        chk("midrst_VALID", {3'b0, VALID}, 4'b0000);
        chk("midrst_OVF", {3'b0, OVF}, 4'b0000);
        rst_n = 1;
        wait_valid(20);
        chk("held_after_rst", D, 4'b1000);
        ACK = 1;
        step(1);
        ACK = 0;
        for (int it = 0; it < 1500; it++) begin
            int hold;
            KEY = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 60) == 0) rst_n = 0;
            for (int k = 0; k < hold; k++) begin
                ACK = ($urandom_range(0, 2) == 0);
                step(1);
                rst_n = 1;
            end
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
